// File: rtl/strobe_period_monitor.sv
// Receive-side monitor for periodic one-cycle strobes: measures the interval between
// rising edges, tracks min/max and event count, and flags out-of-tolerance or missing strobes.
module strobe_period_monitor #(
  parameter int unsigned W        = 24,
  parameter int unsigned EXPECTED = 8388608,
  parameter int unsigned TOL      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic         clear,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic [W-1:0] min_period,
  output logic [W-1:0] max_period,
  output logic [15:0]  n_events,
  output logic         err_fast,
  output logic         err_slow,
  output logic         timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Bounds carry one extra bit so EXPECTED+TOL cannot wrap at the counter width.
  localparam logic [W:0]   EXP_EXT  = (W+1)'(EXPECTED);
  localparam logic [W:0]   TOL_EXT  = (W+1)'(TOL);
  localparam logic [W:0]   LO_BOUND = EXP_EXT - TOL_EXT;
  localparam logic [W:0]   HI_BOUND = EXP_EXT + TOL_EXT;
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t       state_r, state_s;
  logic [W-1:0] cnt_r, cnt_s;
  logic         strobe_d_r;
  logic         strobe_event_s;
  logic [W-1:0] period_s, min_s, max_s;
  logic         valid_s, fast_s, slow_s, timeout_s;
  logic [15:0]  n_events_s;

  assign strobe_event_s = strobe & ~strobe_d_r;

  // Edge detector history; a held-high strobe counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_d_r <= 1'b0;
    end else begin
      strobe_d_r <= strobe;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic; clear overrides both event and saturation.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    period_s   = period;
    valid_s    = 1'b0;
    min_s      = min_period;
    max_s      = max_period;
    n_events_s = n_events;
    fast_s     = err_fast;
    slow_s     = err_slow;
    timeout_s  = timeout;
    if (clear) begin
      state_s    = IDLE;
      cnt_s      = '0;
      min_s      = CNT_MAX;
      max_s      = '0;
      n_events_s = 16'd0;
      fast_s     = 1'b0;
      slow_s     = 1'b0;
      timeout_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (strobe_event_s) begin
            cnt_s      = CNT_ONE;
            n_events_s = n_events + 16'd1;
            state_s    = ARMED;
          end else begin
            cnt_s = '0;
          end
        end
        ARMED: begin
          if (strobe_event_s) begin
            period_s   = cnt_r;
            valid_s    = 1'b1;
            cnt_s      = CNT_ONE;
            n_events_s = n_events + 16'd1;
            min_s      = (cnt_r < min_period) ? cnt_r : min_period;
            max_s      = (cnt_r > max_period) ? cnt_r : max_period;
            fast_s     = err_fast | ({1'b0, cnt_r} < LO_BOUND);
            slow_s     = err_slow | ({1'b0, cnt_r} > HI_BOUND);
          end else if (cnt_r == CNT_MAX) begin
            timeout_s = 1'b1;
            cnt_s     = '0;
            state_s   = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      min_period   <= CNT_MAX;
      max_period   <= '0;
      n_events     <= 16'd0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      period       <= period_s;
      period_valid <= valid_s;
      min_period   <= min_s;
      max_period   <= max_s;
      n_events     <= n_events_s;
      err_fast     <= fast_s;
      err_slow     <= slow_s;
      timeout      <= timeout_s;
    end
  end

endmodule

// File: doc/strobe_period_monitor.md
# strobe_period_monitor

Receive-side checker for periodic one-cycle strobes, such as the slow enable strobes that drive the lab_10 displays and power tests. It detects strobe events and measures the clock-cycle interval between consecutive events. It also keeps min/max statistics and an event count, and raises sticky flags when the interval is out of tolerance or when strobes stop arriving. It sits in the clk domain next to the strobe source and feeds LEDs, 7-segment, or a bench.

## Interface
- W, 24: interval counter width; max measurable interval 2^W-1 cycles
- EXPECTED, 8388608: nominal interval in cycles
- TOL, 2: allowed deviation (cycles) either side of EXPECTED
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- strobe  input  1  monitored strobe, synchronous to clk (no synchronizer inside)
- clear  input  1  synchronous clear of statistics, flags and state
- period  output  W  last measured interval, cycles
- period_valid  output  1  one-cycle pulse: period/min/max just updated
- min_period  output  W  smallest interval since reset/clear
- max_period  output  W  largest interval since reset/clear
- n_events  output  16  count of detected events, wraps 65535->0
- err_fast  output  1  sticky: an interval < EXPECTED-TOL
- err_slow  output  1  sticky: an interval > EXPECTED+TOL
- timeout  output  1  sticky: counter saturated with no event

## Operation
- strobe_d: strobe delayed one cycle, reset 0; event = strobe & ~strobe_d. A strobe held high for N cycles is one event.
- States: IDLE (no reference event), ARMED (measuring since last event).
- IDLE: cnt = 0. On event: cnt <= 1, n_events++, go ARMED; no period reported.
- ARMED, no event: cnt <= cnt+1, saturating at 2^W-1.
  - On an edge where cnt == 2^W-1 and there is no event: timeout <= 1, cnt <= 0, go IDLE.
- ARMED, event: period <= cnt, period_valid <= 1, cnt <= 1, n_events++.
  - min_period <= min(min_period, cnt); max_period <= max(max_period, cnt).
  - err_fast <= err_fast | (cnt < EXPECTED-TOL); err_slow <= err_slow | (cnt > EXPECTED+TOL).
  - Stay ARMED.
- Event while cnt == 2^W-1: the event wins. Period is 2^W-1, err_slow is set, timeout is not set.
- clear (priority over event and saturation):
  - state IDLE, cnt 0, period_valid 0.
  - min_period all-ones, max_period 0, n_events 0, all flags 0.
  - period holds its value.
- Comparisons are unsigned. EXPECTED-TOL and EXPECTED+TOL are computed at W+1 bits, so the bounds do not wrap.
- Reset values:
  - state IDLE, cnt 0, strobe_d 0.
  - period 0, period_valid 0, min_period all-ones, max_period 0, n_events 0.
  - err_fast/err_slow/timeout 0.

## Timing
- All outputs are registered.
- For events at edges t and t+P, the value captured into period is exactly P.
- period, period_valid, min/max, n_events and flags update at the event edge and are visible the following cycle.
- period_valid is high for exactly one cycle per measured interval. It is never asserted for the arming event.
- Back-to-back events are impossible: a rising edge needs strobe low in between. The minimum reportable interval is 2.
- rst_n assertion mid-interval forces all reset values immediately. The first event after release only arms.

## Test plan
- Use W=8, EXPECTED=16, TOL=1 throughout.
- One-cycle strobe every 16 cycles, 5 pulses:
  - 4 period_valid pulses, each with period=16.
  - min=max=16, n_events=5, all flags 0.
- Intervals 14, 16, 18:
  - err_fast set after the 14 interval, err_slow set after the 18 interval.
  - min=14, max=18, both flags stay set afterwards.
- Arm, then no strobe for 300 cycles:
  - timeout rises when cnt hits 255 (255 cycles after arming), state goes IDLE.
  - Next strobe produces no period_valid; a strobe 16 cycles later reports period=16.
- Strobe held high 5 cycles, then a 1-cycle pulse 20 cycles after the first rising edge: one event each, period=20, err_slow=1.
- clear in the same cycle as a strobe rising edge:
  - stats and flags reset, n_events=0, no period_valid.
  - Next strobe only arms.
- rst_n pulsed low between strobes while ARMED: outputs return to reset values asynchronously, and the next two strobes 16 apart report period=16.
